// File: rtl/shift_add_mul_pkg.sv
// shift_add_mul_pkg: state encoding and default width for the shift-and-add multiplier
package shift_add_mul_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/rca_w.sv
// rca_w: WIDTH-bit ripple-carry adder built from a chain of full-adder cells
module rca_w #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  for (genvar g = 0; g < WIDTH; g++) begin : g_fa
    assign sum[g]  = a[g] ^ b[g] ^ c[g];
    assign c[g+1]  = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
  end
  assign cout = c[WIDTH];
endmodule

// File: rtl/shift_add_mul_ctrl.sv
// shift_add_mul_ctrl: sequential unsigned multiplier reusing one ripple-carry adder over WIDTH cycles
module shift_add_mul_ctrl
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);
  localparam int CW = $clog2(WIDTH);
  state_t             state;
  logic [WIDTH-1:0]   mc;
  logic [2*WIDTH-1:0] pr;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] pr_next;
  logic               last;
  assign addend  = pr[0] ? mc : '0;
  rca_w #(.WIDTH(WIDTH)) u_add (
    .a    (pr[2*WIDTH-1:WIDTH]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );
  assign pr_next = {cout, sum, pr[WIDTH-1:1]};
  assign last    = cnt == CW'(WIDTH - 1);
  assign ready   = state == IDLE;
  assign busy    = (state == RUN) || (state == DONE);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mc    <= '0;
      pr    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      P     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mc    <= X;
          pr    <= {{WIDTH{1'b0}}, Y};
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          pr  <= pr_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
            P     <= pr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// tb_shift_add_mul_ctrl: randomized directed checks of the multiplier against plain X*Y arithmetic
module tb_shift_add_mul_ctrl;
  localparam int W = 4;
  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   X;
  logic [W-1:0]   Y;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] P;
  logic [2*W-1:0] p_last;
  int             checks = 0;
  int             errors = 0;
  int             n;
  shift_add_mul_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X     (X),
    .Y     (Y),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(input bit noise);
    n = 0;
    while (!done && n < 30) begin
      check("p_hold", 32'(P), 32'(p_last));
      if (noise) begin
        start = 1'($urandom);
        X     = W'($urandom);
        Y     = W'($urandom);
      end
      tick();
      n++;
    end
    start = 1'b0;
    check("latency", n, W);
    check("busy_in_done", 32'(busy), 1);
  endtask
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit noise);
    logic [2*W-1:0] exp;
    exp   = (2*W)'(x) * (2*W)'(y);
    X     = x;
    Y     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ready_fall", 32'(ready), 0);
    check("busy_rise", 32'(busy), 1);
    wait_done(noise);
    check("product", 32'(P), 32'(exp));
    p_last = exp;
    tick();
    check("done_single", 32'(done), 0);
    check("ready_back", 32'(ready), 1);
    check("busy_fall", 32'(busy), 0);
    check("p_stable", 32'(P), 32'(exp));
  endtask
  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    X      = '0;
    Y      = '0;
    p_last = '0;
    tick();
    tick();
    check("rst_ready", 32'(ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_p", 32'(P), 0);
    rst = 1'b0;
    tick();
    run_op(4'd3, 4'd5, 1'b0);
    run_op(4'd15, 4'd15, 1'b1);
    run_op(4'd0, 4'd9, 1'b1);
    run_op(4'd9, 4'd0, 1'b1);
    // start held high across two operations, operands changed mid-run
    X     = 4'd7;
    Y     = 4'd6;
    start = 1'b1;
    tick();
    X = 4'd2;
    Y = 4'd11;
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    check("hold_latency1", n, W);
    check("hold_p1", 32'(P), 42);
    tick();
    check("hold_idle", 32'(ready), 1);
    tick();
    check("hold_accept", 32'(ready), 0);
    start  = 1'b0;
    p_last = 8'd42;
    wait_done(1'b0);
    check("hold_p2", 32'(P), 22);
    p_last = 8'd22;
    tick();
    // reset aborts an in-flight operation
    X     = 4'd13;
    Y     = 4'd11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(ready), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_p", 32'(P), 0);
    tick();
    rst = 1'b0;
    p_last = '0;
    for (int i = 0; i < 8; i++) begin
      check("abort_no_done", 32'(done), 0);
      tick();
    end
    run_op(4'd13, 4'd11, 1'b0);
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run_op(W'(x), W'(y), 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
